index_vector_loader: RTL
========================

Name: index_vector_loader

Overview:
- Upstream feeder of the top controller's index-vector path.
- Fetches packed 7-bit activation indices from index SRAM and assembles them into 224-bit (32 x 7-bit) index vectors.
- Holds assembled vectors in a 2-entry vector FIFO and presents the head on index_vector_buffer with a one-cycle index_en strobe; empty reports "no vector available".
- The controller pops a vector with consume, driven by pe_done.

Parameters:
- IDX_W, 7, bits per index.
- IDX_NUM, 32, indices per vector.
- IDX_PER_WORD, 4, indices per SRAM word (word width = IDX_PER_WORD*IDX_W = 28).
- ADDR_W, 16, SRAM address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that launches a job; ignored while busy=1.
- base_addr  in  16  first SRAM word address, sampled on start.
- num_vectors  in  16  vectors in the job, sampled on start.
- sram_rd_en  out  1  SRAM read request.
- sram_rd_addr  out  16  SRAM word address.
- sram_rd_data  in  28  SRAM read data, valid exactly 1 cycle after sram_rd_en.
- consume  in  1  pop FIFO head (controller pe_done).
- index_vector_buffer  out  224  FIFO head vector.
- index_en  out  1  one-cycle strobe: a new head is presented.
- empty  out  1  FIFO count == 0.
- busy  out  1  job active.
- done  out  1  one-cycle pulse: last vector of the job pushed into the FIFO.

Behaviour:
- Reset (rst_n=0, async, any time including mid-job):
  - sram_rd_en=0, sram_rd_addr=0, index_vector_buffer=0, index_en=0, empty=1, busy=0, done=0.
  - FIFO count, beat counter and vector counter cleared; state IDLE.
  - An SRAM read in flight at reset is discarded.
- FSM states:
  - IDLE -> LOAD on start (latch base_addr and num_vectors; busy=1 from the next cycle).
  - If num_vectors==0, go to FINISH instead; no reads are issued.
  - LOAD: issue reads while reserved<2, where reserved = FIFO count + (1 if a vector is in assembly). When reserved==2 at beat 0, stall with sram_rd_en=0.
  - LOAD -> FINISH when the final word of the final vector has been issued and has returned.
  - FINISH: done=1 for one cycle, then -> IDLE, busy=0.
- Read issue:
  - One word per cycle.
  - sram_rd_addr starts at base_addr and increments by 1 per issued word, wrapping 16'hFFFF -> 0.
  - Beat counter runs 0..7 per vector (IDX_NUM/IDX_PER_WORD = 8 words).
- Assembly:
  - Word returned for beat k: its index j (bits [7j+6:7j]) lands in vector bits [(4k+j)*7 +: 7].
  - On the cycle the beat-7 data returns, the vector is pushed.
  - A vector's reservation is taken when its beat 0 is issued.
- FIFO, 2 entries:
  - index_vector_buffer is driven from the head register; it is 0 when empty.
  - consume with count>0 pops the head; consume when empty is ignored (no underflow).
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Overflow cannot occur by construction of the reservation rule. A push at count==2 is an assertion failure.
- index_en:
  - Asserted for one cycle, the cycle after a new vector becomes head: either a push into an empty FIFO, or a pop that leaves count>=1.
  - index_vector_buffer is stable and valid while index_en=1 and until the next pop.
- empty updates registered, in the same cycle as count.
- done pulses even if vectors remain unconsumed in the FIFO. busy falls after done; the FIFO continues to drain via consume.
- start while busy is ignored.
- Latency: the first index_en arrives 10 cycles after start (1 cycle start latch + 8 issue cycles + 1 return + push/strobe), for a non-stalled job.

Decomposition:
- Shared package holds:
  - IDX_W, IDX_NUM, IDX_PER_WORD, ADDR_W, VEC_W=224, WORDS_PER_VEC=8.
  - The loader state encoding IDLE/LOAD/FINISH.
- One sub-module: index_vec_fifo. It is a 2-entry 224-bit FIFO with push, pop, head, count, empty, and head_new strobe generation.

Test Plan:
- Single vector: base_addr=0x0010, num_vectors=1, SRAM word at addr a = pattern {7'(4a+3),7'(4a+2),7'(4a+1),7'(4a)}.
  - Expected: addresses 0x10..0x17 issued on consecutive cycles.
  - Expected: index_en once at start+10.
  - Expected: vector index i == 7'(64+i) for i=0..31; done pulse; empty=0.
- Backpressure: num_vectors=4, consume never asserted.
  - Expected: exactly 16 reads, then sram_rd_en held 0; count=2.
  - Expected: after one consume, reads resume with 8 more words; head shows vector 1 with index_en.
- Simultaneous push/pop: consume asserted the same cycle vector 2 is pushed with count=1.
  - Expected: count stays 1; index_en pulses; head = vector 2.
- Address wrap: base_addr=0xFFFC, num_vectors=1.
  - Expected: addresses FFFC, FFFD, FFFE, FFFF, 0000, 0001, 0002, 0003.
- Corner inputs: num_vectors=0 gives a done pulse 2 cycles after start, no sram_rd_en, empty stays 1. consume while empty leaves count=0. start while busy leaves the job unchanged.
- Async reset mid-LOAD after 3 beats: all outputs return to reset values immediately, the late SRAM return is ignored, and a fresh start works normally.

Source files
------------

// File: rtl/index_vector_loader_pkg.sv
// Shared widths and state encoding for the index-vector loader and its output FIFO.
package index_vector_loader_pkg;

  localparam int IDX_W         = 7;
  localparam int IDX_NUM       = 32;
  localparam int IDX_PER_WORD  = 4;
  localparam int ADDR_W        = 16;
  localparam int WORD_W        = IDX_PER_WORD * IDX_W;
  localparam int VEC_W         = IDX_NUM * IDX_W;
  localparam int WORDS_PER_VEC = IDX_NUM / IDX_PER_WORD;
  localparam int BEAT_W        = $clog2(WORDS_PER_VEC);
  localparam int CNT_W         = 2;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_VEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
  } loader_state_e;

endpackage

// File: rtl/index_vector_loader_index_vec_fifo.sv
// Two-entry vector FIFO: head register drives the output (zero when empty),
// and head_new strobes the cycle after a different vector becomes head.
module index_vec_fifo
  import index_vector_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [VEC_W-1:0] push_data,
  input  logic             pop,
  output logic [VEC_W-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             head_new
);

  logic [VEC_W-1:0] head_q, head_d;
  logic [VEC_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, empty_d;
  logic             head_new_q, head_new_d;
  logic             pop_ok;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    head_new_d = 1'b0;
    pop_ok     = pop && (count_q != 2'd0);

    if (push && pop_ok) begin
      if (count_q == 2'd1) begin
        head_d = push_data;
      end else begin
        head_d = tail_q;
        tail_d = push_data;
      end
      head_new_d = 1'b1;
    end else if (push) begin
      if (count_q == 2'd0) begin
        head_d     = push_data;
        head_new_d = 1'b1;
      end else begin
        tail_d = push_data;
      end
      count_d = count_q + 2'd1;
    end else if (pop_ok) begin
      // Popping the last entry clears the head so the output reads zero when empty.
      if (count_q == 2'd2) begin
        head_d     = tail_q;
        head_new_d = 1'b1;
      end else begin
        head_d = '0;
      end
      count_d = count_q - 2'd1;
    end

    empty_d = (count_d == 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      head_new_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      head_new_q <= head_new_d;
    end
  end

  // The loader's reservation rule must make a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && (count_q == 2'd2)));

  assign head     = head_q;
  assign count    = count_q;
  assign empty    = empty_q;
  assign head_new = head_new_q;

endmodule

// File: rtl/index_vector_loader.sv
// Fetches packed 7-bit indices from SRAM, assembles 32-index vectors and
// queues them in a two-entry FIFO for the controller to consume.
module index_vector_loader
  import index_vector_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_vectors,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_rd_addr,
  input  logic [WORD_W-1:0] sram_rd_data,
  input  logic              consume,
  output logic [VEC_W-1:0]  index_vector_buffer,
  output logic              index_en,
  output logic              empty,
  output logic              busy,
  output logic              done
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] issue_left_q, issue_left_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [BEAT_W-1:0] ret_beat_q, ret_beat_d;
  logic [CNT_W-1:0]  resv_q, resv_d;
  logic              rd_pend_q, rd_pend_d;
  logic              ret_last_q, ret_last_d;
  logic              done_q, done_d;
  logic [VEC_W-1:0]  asm_q, asm_d;

  logic              issue;
  logic              issue_first;
  logic              pop_ok;
  logic              push;
  logic [CNT_W-1:0]  fifo_count;

  // resv_q counts FIFO entries plus vectors whose beat 0 has gone out but
  // which are not yet pushed; a new vector may only start while it is below 2.
  always_comb begin
    issue       = (state_q == ST_LOAD) && (issue_left_q != '0) &&
                  ((beat_q != '0) || (resv_q < 2'd2));
    issue_first = issue && (beat_q == '0);
    pop_ok      = consume && (fifo_count != 2'd0);
    push        = rd_pend_q && (ret_beat_q == LAST_BEAT);
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    beat_d       = beat_q;
    resv_d       = resv_q + {1'b0, issue_first} - {1'b0, pop_ok};
    rd_pend_d    = issue;
    ret_beat_d   = beat_q;
    ret_last_d   = issue && (beat_q == LAST_BEAT) && (issue_left_q == 16'd1);
    done_d       = (state_q == ST_FINISH);
    asm_d        = asm_q;

    for (int b = 0; b < WORDS_PER_VEC; b++) begin
      if (rd_pend_q && (ret_beat_q == BEAT_W'(b))) begin
        asm_d[b*WORD_W +: WORD_W] = sram_rd_data;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        // done_q still high means the previous job is reporting busy.
        if (start && !done_q) begin
          addr_d       = base_addr;
          issue_left_d = num_vectors;
          beat_d       = '0;
          state_d      = (num_vectors == '0) ? ST_FINISH : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (issue) begin
          addr_d = addr_q + 16'd1;
          beat_d = beat_q + 3'd1;
          if (beat_q == LAST_BEAT) begin
            issue_left_d = issue_left_q - 16'd1;
          end
        end
        if (rd_pend_q && ret_last_q) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      beat_q       <= '0;
      ret_beat_q   <= '0;
      resv_q       <= '0;
      rd_pend_q    <= 1'b0;
      ret_last_q   <= 1'b0;
      done_q       <= 1'b0;
      asm_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      beat_q       <= beat_d;
      ret_beat_q   <= ret_beat_d;
      resv_q       <= resv_d;
      rd_pend_q    <= rd_pend_d;
      ret_last_q   <= ret_last_d;
      done_q       <= done_d;
      asm_q        <= asm_d;
    end
  end

  index_vec_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (asm_d),
    .pop       (consume),
    .head      (index_vector_buffer),
    .count     (fifo_count),
    .empty     (empty),
    .head_new  (index_en)
  );

  assign sram_rd_en   = issue;
  assign sram_rd_addr = addr_q;
  assign busy         = (state_q != ST_IDLE) || done_q;
  assign done         = done_q;

endmodule
